pad_power_sequencer: RTL and testbench

PAD_POWER_SEQUENCER -- requirements
Module: pad_power_sequencer

---
 rtl/pwrseq_pkg.sv | 20 ++
 rtl/pwrseq_filter.sv | 41 ++++
 rtl/pad_power_sequencer.sv | 127 ++++++++++++
 tb/tb_pad_power_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pwrseq_pkg.sv
// Shared state encoding and timing defaults for the pad power sequencer.
package pwrseq_pkg;

   localparam int DEBOUNCE_CYC_DEF  = 16;
   localparam int IO_SETTLE_CYC_DEF = 32;

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_WAIT_IO   = 3'd1,
      ST_WAIT_CORE = 3'd2,
      ST_IO_SETTLE = 3'd3,
      ST_ON        = 3'd4,
      ST_FAULT     = 3'd5
   } pwr_state_t;

   function automatic logic pads_on(input pwr_state_t s);
      return (s == ST_IO_SETTLE) || (s == ST_ON);
   endfunction

endpackage

// File: rtl/pwrseq_filter.sv
// Two-flop synchronizer plus debounce for one asynchronous power-good flag.
module pwrseq_filter
   import pwrseq_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filt
);

   localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

   logic          meta;
   logic          sampled;
   logic [CW-1:0] cnt;

   // Count consecutive samples that disagree with the accepted level.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta    <= 1'b0;
         sampled <= 1'b0;
         cnt     <= '0;
         filt    <= 1'b0;
      end else begin
         meta    <= raw;
         sampled <= meta;
         if (sampled == filt) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt  <= '0;
            filt <= sampled;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/pad_power_sequencer.sv
// Pad-ring / core power-up sequencer with filtered power-good inputs.
// Define PWRSEQ_FAULT_LATCH_EN to latch power-good loss in FAULT.
module pad_power_sequencer
   import pwrseq_pkg::*;
#(
   parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
   parameter int IO_SETTLE_CYC = IO_SETTLE_CYC_DEF
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       vddio_good_i,
   input  logic       vccd_good_i,
   input  logic       force_off_i,
   input  logic       fault_clr_i,
   output logic       io_pad_en_o,
   output logic       core_rst_n_o,
   output logic       pwr_ready_o,
   output logic       fault_o,
   output logic [2:0] state_o
);

   localparam int SW = $clog2(IO_SETTLE_CYC) + 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(IO_SETTLE_CYC - 1);
   localparam logic [SW-1:0] SETTLE_MAX  = '1;

`ifdef PWRSEQ_FAULT_LATCH_EN
   localparam pwr_state_t LOSS_ST = ST_FAULT;
`else
   localparam pwr_state_t LOSS_ST = ST_OFF;
`endif

   pwr_state_t    state;
   pwr_state_t    state_nxt;
   logic [SW-1:0] settle;
   logic [SW-1:0] settle_nxt;
   logic          vddio_ok;
   logic          vccd_ok;
   logic          pg_ok;

   pwrseq_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_vddio (
      .clk  (wb_clk_i),
      .rst  (wb_rst_i),
      .raw  (vddio_good_i),
      .filt (vddio_ok)
   );

   pwrseq_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_vccd (
      .clk  (wb_clk_i),
      .rst  (wb_rst_i),
      .raw  (vccd_good_i),
      .filt (vccd_ok)
   );

   assign pg_ok = vddio_ok & vccd_ok;

   // force_off_i is checked first so it wins over a simultaneous loss.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_OFF: begin
            if (!force_off_i) state_nxt = ST_WAIT_IO;
         end
         ST_WAIT_IO: begin
            if (force_off_i)   state_nxt = ST_OFF;
            else if (vddio_ok) state_nxt = ST_WAIT_CORE;
         end
         ST_WAIT_CORE: begin
            if (force_off_i)    state_nxt = ST_OFF;
            else if (!vddio_ok) state_nxt = LOSS_ST;
            else if (vccd_ok)   state_nxt = ST_IO_SETTLE;
         end
         ST_IO_SETTLE: begin
            if (force_off_i)  state_nxt = ST_OFF;
            else if (!pg_ok)  state_nxt = LOSS_ST;
            else if (settle == SETTLE_LAST)
               state_nxt = ST_ON;
         end
         ST_ON: begin
            if (force_off_i) state_nxt = ST_OFF;
            else if (!pg_ok) state_nxt = LOSS_ST;
         end
         ST_FAULT: begin
            if (fault_clr_i) state_nxt = ST_OFF;
         end
         default: state_nxt = ST_OFF;
      endcase
   end

   always_comb begin
      settle_nxt = '0;
      if (state == ST_IO_SETTLE && state_nxt == ST_IO_SETTLE)
         settle_nxt = (settle == SETTLE_MAX) ? settle : settle + SW'(1);
   end

   // Outputs decode the next state so they change with the state register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state        <= ST_OFF;
         settle       <= '0;
         io_pad_en_o  <= 1'b0;
         core_rst_n_o <= 1'b0;
         pwr_ready_o  <= 1'b0;
      end else begin
         state        <= state_nxt;
         settle       <= settle_nxt;
         io_pad_en_o  <= pads_on(state_nxt);
         core_rst_n_o <= (state_nxt == ST_ON);
         pwr_ready_o  <= (state_nxt == ST_ON);
      end
   end

`ifdef PWRSEQ_FAULT_LATCH_EN
   logic fault_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) fault_q <= 1'b0;
      else          fault_q <= (state_nxt == ST_FAULT);
   end

   assign fault_o = fault_q;
`else
   assign fault_o = 1'b0;
`endif

   assign state_o = state;

endmodule

// File: tb/tb_pad_power_sequencer.sv
// Directed self-checking bench for pad_power_sequencer (default parameters).
module tb_pad_power_sequencer;

`ifdef PWRSEQ_FAULT_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i;
   logic       vddio_good_i;
   logic       vccd_good_i;
   logic       force_off_i;
   logic       fault_clr_i;
   logic       io_pad_en_o;
   logic       core_rst_n_o;
   logic       pwr_ready_o;
   logic       fault_o;
   logic [2:0] state_o;

   int errors = 0;
   int checks = 0;

   pad_power_sequencer dut (
      .wb_clk_i     (wb_clk_i),
      .wb_rst_i     (wb_rst_i),
      .vddio_good_i (vddio_good_i),
      .vccd_good_i  (vccd_good_i),
      .force_off_i  (force_off_i),
      .fault_clr_i  (fault_clr_i),
      .io_pad_en_o  (io_pad_en_o),
      .core_rst_n_o (core_rst_n_o),
      .pwr_ready_o  (pwr_ready_o),
      .fault_o      (fault_o),
      .state_o      (state_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic cyc(input int n);
      repeat (n) @(posedge wb_clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2:0] st,
                      input logic pad, input logic rstn,
                      input logic rdy, input logic flt);
      logic [6:0] obs;
      logic [6:0] want;
      obs  = {state_o, io_pad_en_o, core_rst_n_o, pwr_ready_o, fault_o};
      want = {st, pad, rstn, rdy, flt};
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b (state,pad,rst_n,ready,fault)",
                tag, obs, want);
      end
   endtask

   initial begin
      wb_rst_i     = 1'b1;
      vddio_good_i = 1'b1;
      vccd_good_i  = 1'b1;
      force_off_i  = 1'b0;
      fault_clr_i  = 1'b0;

      // reset held: stays OFF with both goods already high
      cyc(3);
      chk("reset", 3'd0, 0, 0, 0, 0);
      cyc(1);
      chk("reset_hold", 3'd0, 0, 0, 0, 0);
      wb_rst_i = 1'b0;

      // power-up: filters accept at edge 18
      cyc(1);
      chk("wait_io", 3'd1, 0, 0, 0, 0);
      cyc(17);
      chk("wait_io_last", 3'd1, 0, 0, 0, 0);
      cyc(1);
      chk("wait_core", 3'd2, 0, 0, 0, 0);
      cyc(1);
      chk("settle_entry", 3'd3, 1, 0, 0, 0);
      cyc(31);
      chk("settle_last", 3'd3, 1, 0, 0, 0);
      cyc(1);
      chk("on", 3'd4, 1, 1, 1, 0);

      // vccd dropped for 20 cycles while ON
      cyc(3);
      vccd_good_i = 1'b0;
      cyc(18);
      chk("loss_pending", 3'd4, 1, 1, 1, 0);
      cyc(1);
      chk("loss", LATCH ? 3'd5 : 3'd0, 0, 0, 0, LATCH);
      cyc(1);
      vccd_good_i = 1'b1;
      cyc(4);
      chk("loss_hold", LATCH ? 3'd5 : 3'd2, 0, 0, 0, LATCH);
      fault_clr_i = 1'b1;
      cyc(1);
      fault_clr_i = 1'b0;
      chk("fault_clr", LATCH ? 3'd0 : 3'd2, 0, 0, 0, 0);
      cyc(13);
      chk("reseq_wait", 3'd2, 0, 0, 0, 0);
      cyc(1);
      chk("reseq_settle", 3'd3, 1, 0, 0, 0);
      cyc(32);
      chk("reseq_on", 3'd4, 1, 1, 1, 0);

      // force_off and accepted vddio loss in the same cycle
      cyc(2);
      vddio_good_i = 1'b0;
      cyc(18);
      chk("both_pending", 3'd4, 1, 1, 1, 0);
      force_off_i = 1'b1;
      cyc(1);
      chk("force_prio", 3'd0, 0, 0, 0, 0);
      cyc(3);
      chk("force_hold", 3'd0, 0, 0, 0, 0);

      // vddio chattering every 5 cycles is never accepted
      force_off_i = 1'b0;
      for (int i = 0; i < 12; i++) begin
         vddio_good_i = ~vddio_good_i;
         cyc(5);
         chk("toggle", 3'd1, 0, 0, 0, 0);
      end
      vddio_good_i = 1'b1;
      cyc(18);
      chk("stable_last", 3'd1, 0, 0, 0, 0);
      cyc(1);
      chk("stable_core", 3'd2, 0, 0, 0, 0);
      cyc(1);
      chk("stable_settle", 3'd3, 1, 0, 0, 0);

      // reset pulse in IO_SETTLE restarts from OFF
      cyc(5);
      wb_rst_i = 1'b1;
      cyc(1);
      chk("mid_reset", 3'd0, 0, 0, 0, 0);
      wb_rst_i = 1'b0;
      cyc(1);
      chk("restart_io", 3'd1, 0, 0, 0, 0);
      cyc(18);
      chk("restart_core", 3'd2, 0, 0, 0, 0);
      cyc(1);
      chk("restart_settle", 3'd3, 1, 0, 0, 0);
      cyc(31);
      chk("restart_last", 3'd3, 1, 0, 0, 0);
      cyc(1);
      chk("restart_on", 3'd4, 1, 1, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
